// File: rtl/cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor: WIDTH bits split into STAGES slices,
// each slice resolved by BLOCK-bit lookahead groups, with a valid/ready handshake.
module cla_pipe #(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int SW   = WIDTH / STAGES;
    localparam int NG   = SW / BLOCK;
    localparam int LAST = STAGES - 1;
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

    // One slice: group generate/propagate, lookahead across groups, short ripple inside a group.
    function automatic logic [SW:0] cla_slice(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                              input logic c);
        logic [SW-1:0] g, p, cb;
        logic [NG-1:0] gg, gp;
        logic [NG:0]   gc;
        logic          term;
        g = x & y;
        p = x ^ y;
        for (int j = 0; j < NG; j++) begin
            gg[j] = 1'b0;
            gp[j] = 1'b1;
            for (int i = 0; i < BLOCK; i++) begin
                gg[j] = g[j*BLOCK+i] | (p[j*BLOCK+i] & gg[j]);
                gp[j] = gp[j] & p[j*BLOCK+i];
            end
        end
        for (int j = 0; j <= NG; j++) begin
            gc[j] = c;
            for (int i = 0; i < j; i++) gc[j] = gc[j] & gp[i];
            for (int i = 0; i < j; i++) begin
                term = gg[i];
                for (int k = i + 1; k < j; k++) term = term & gp[k];
                gc[j] = gc[j] | term;
            end
        end
        for (int j = 0; j < NG; j++) begin
            cb[j*BLOCK] = gc[j];
            for (int i = 1; i < BLOCK; i++)
                cb[j*BLOCK+i] = g[j*BLOCK+i-1] | (p[j*BLOCK+i-1] & cb[j*BLOCK+i-1]);
        end
        return {gc[NG], p ^ cb};
    endfunction

    logic [WIDTH-1:0] a_r [STAGES];
    logic [WIDTH-1:0] b_r [STAGES];
    logic [WIDTH-1:0] s_r [STAGES];
    logic [STAGES-1:0] c_r, v_r;

    logic [WIDTH-1:0] ain_s [STAGES];
    logic [WIDTH-1:0] bin_s [STAGES];
    logic [WIDTH-1:0] sin_s [STAGES];
    logic [WIDTH-1:0] snx_s [STAGES];
    logic [SW:0]      slice_s [STAGES];
    logic [STAGES-1:0] ci_s, vin_s, cnx_s;

    logic cout_r, ovf_r, zero_r, neg_r;
    logic ovf_s, zero_s, neg_s;
    logic en_s;

    assign en_s     = out_ready | ~v_r[LAST];
    assign in_ready = en_s;

    // Stage inputs (operand B already inverted for subtract) and per-stage slice resolution.
    always_comb begin
        ain_s[0] = in_valid ? a : ZERO_W;
        bin_s[0] = in_valid ? (sub ? ~b : b) : ZERO_W;
        sin_s[0] = ZERO_W;
        ci_s[0]  = in_valid & (sub ? ~cin : cin);
        vin_s[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            ain_s[k] = a_r[k-1];
            bin_s[k] = b_r[k-1];
            sin_s[k] = s_r[k-1];
            ci_s[k]  = c_r[k-1];
            vin_s[k] = v_r[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            slice_s[k]              = cla_slice(ain_s[k][k*SW +: SW], bin_s[k][k*SW +: SW], ci_s[k]);
            snx_s[k]                = sin_s[k];
            snx_s[k][k*SW +: SW]    = slice_s[k][SW-1:0];
            cnx_s[k]                = slice_s[k][SW];
        end
    end

    // Result flags are derived in the final stage so they register alongside the sum.
    always_comb begin
        zero_s = (snx_s[LAST] == ZERO_W);
        neg_s  = snx_s[LAST][WIDTH-1];
        ovf_s  = (ain_s[LAST][WIDTH-1] == bin_s[LAST][WIDTH-1]) &&
                 (snx_s[LAST][WIDTH-1] != ain_s[LAST][WIDTH-1]);
    end

    // Pipeline registers: whole pipe shifts together on en_s, holds otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_r[k] <= ZERO_W;
                b_r[k] <= ZERO_W;
                s_r[k] <= ZERO_W;
            end
            c_r    <= {STAGES{1'b0}};
            v_r    <= {STAGES{1'b0}};
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
            neg_r  <= 1'b0;
        end else if (en_s) begin
            for (int k = 0; k < STAGES; k++) begin
                a_r[k] <= ain_s[k];
                b_r[k] <= bin_s[k];
                s_r[k] <= snx_s[k];
            end
            c_r    <= cnx_s;
            v_r    <= vin_s;
            cout_r <= cnx_s[LAST];
            ovf_r  <= ovf_s;
            zero_r <= zero_s;
            neg_r  <= neg_s;
        end
    end

    assign out_valid = v_r[LAST];
    assign sum       = s_r[LAST];
    assign cout      = cout_r;
    assign ovf       = ovf_r;
    assign zero      = zero_r;
    assign neg       = neg_r;

endmodule
